// File: rtl/eth_mux_sched_pkg.sv
// Shared definitions for the Ethernet mux frame scheduler.
package eth_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACTIVE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/eth_mux_sched_if.sv
// Request/handshake and mux-control bundle between the scheduler and its Ethernet mux.
interface eth_mux_sched_if #(
    parameter int S_COUNT     = 4,
    parameter int COUNT_WIDTH = 16
);
    localparam int SEL_W = $clog2(S_COUNT);

    logic [S_COUNT-1:0]     req;
    logic [S_COUNT-1:0]     port_mask;
    logic                   m_hdr_valid;
    logic                   m_tvalid;
    logic                   m_tready;
    logic                   m_tlast;
    logic                   enable;
    logic [SEL_W-1:0]       select;
    logic [S_COUNT-1:0]     grant;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] frame_count;

    modport master (
        input  req, port_mask, m_hdr_valid, m_tvalid, m_tready, m_tlast,
        output enable, select, grant, busy, frame_count
    );

    modport slave (
        output req, port_mask, m_hdr_valid, m_tvalid, m_tready, m_tlast,
        input  enable, select, grant, busy, frame_count
    );
endinterface

// File: rtl/eth_mux_sched_pick.sv
// Combinational winner search: rotate the request vector, priority-encode, un-rotate.
module eth_sched_pick #(
    parameter int S_COUNT = 4,
    parameter int IDX_W   = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    input  logic               i_rr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_found
);
    logic [IDX_W-1:0]     w_start;
    logic [2*S_COUNT-1:0] w_dbl;
    logic [S_COUNT-1:0]   w_rot;
    logic [IDX_W-1:0]     w_ofs;
    logic [IDX_W:0]       w_sum;

    always_comb begin
        w_start = '0;
        if (i_rr && (i_last_grant != IDX_W'(S_COUNT - 1))) begin
            w_start = i_last_grant + IDX_W'(1);
        end
        w_dbl = {i_req, i_req} >> w_start;
        w_rot = w_dbl[S_COUNT-1:0];

        // Descending scan so the lowest rotated index is the one that sticks.
        w_ofs   = '0;
        o_found = 1'b0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_ofs   = IDX_W'(i);
                o_found = 1'b1;
            end
        end

        w_sum = {1'b0, w_start} + {1'b0, w_ofs};
        if (w_sum >= (IDX_W + 1)'(S_COUNT)) begin
            w_sum = w_sum - (IDX_W + 1)'(S_COUNT);
        end
        o_winner = w_sum[IDX_W-1:0];
    end
endmodule

// File: rtl/eth_mux_sched.sv
// Frame-granular round-robin / fixed-priority scheduler driving an Ethernet mux enable/select.
module eth_mux_sched
    import eth_sched_pkg::*;
#(
    parameter int S_COUNT         = 4,
    parameter int ARB_ROUND_ROBIN = 1,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic            clk,
    input  logic            rst,
    eth_mux_sched_if.master bus
);
    localparam int   IDX_W = $clog2(S_COUNT);
    localparam logic RR    = (ARB_ROUND_ROBIN != 0);

    sched_state_t           r_state, w_state_nxt;
    logic                   r_enable, w_enable_nxt;
    logic [IDX_W-1:0]       r_select, w_select_nxt;
    logic [S_COUNT-1:0]     r_grant, w_grant_nxt;
    logic                   r_busy, w_busy_nxt;
    logic [COUNT_WIDTH-1:0] r_frame_count, w_count_nxt;
    logic [IDX_W-1:0]       r_last_grant, w_last_nxt;

    logic [S_COUNT-1:0]     w_eligible;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_found;
    logic                   w_tlast_hs;

    assign w_eligible = bus.req & bus.port_mask;
    assign w_tlast_hs = bus.m_tvalid & bus.m_tready & bus.m_tlast;

    eth_sched_pick #(
        .S_COUNT (S_COUNT),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req        (w_eligible),
        .i_last_grant (r_last_grant),
        .i_rr         (RR),
        .o_winner     (w_winner),
        .o_found      (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enable_nxt = r_enable;
        w_select_nxt = r_select;
        w_grant_nxt  = r_grant;
        w_count_nxt  = r_frame_count;
        w_last_nxt   = r_last_grant;

        case (r_state)
            ST_IDLE: begin
                w_enable_nxt = 1'b0;
                w_grant_nxt  = '0;
                if (w_found) begin
                    w_select_nxt = w_winner;
                    w_grant_nxt  = {{(S_COUNT-1){1'b0}}, 1'b1} << w_winner;
                    w_enable_nxt = 1'b1;
                    w_state_nxt  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A header already latched by the mux must not be abandoned.
                if (bus.m_hdr_valid) begin
                    w_enable_nxt = 1'b0;
                    w_state_nxt  = ST_ACTIVE;
                end else if (!bus.req[r_select] || !bus.port_mask[r_select]) begin
                    w_enable_nxt = 1'b0;
                    w_grant_nxt  = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                w_enable_nxt = 1'b0;
                if (w_tlast_hs) begin
                    w_grant_nxt = '0;
                    w_count_nxt = r_frame_count + COUNT_WIDTH'(1);
                    w_last_nxt  = r_select;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_enable_nxt = 1'b0;
                w_grant_nxt  = '0;
                w_state_nxt  = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable      <= 1'b0;
            r_select      <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
            r_last_grant  <= IDX_W'(S_COUNT - 1);
        end else begin
            r_enable      <= w_enable_nxt;
            r_select      <= w_select_nxt;
            r_grant       <= w_grant_nxt;
            r_busy        <= w_busy_nxt;
            r_frame_count <= w_count_nxt;
            r_last_grant  <= w_last_nxt;
        end
    end

    assign bus.enable      = r_enable;
    assign bus.select      = r_select;
    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.frame_count = r_frame_count;
endmodule

// File: tb/tb_eth_mux_sched.sv
// Directed bench for eth_mux_sched: cycle vector table plus round-robin, backpressure and fixed-priority sequences.
module tb_eth_mux_sched;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    eth_mux_sched_if #(.S_COUNT(4), .COUNT_WIDTH(16)) bus_rr ();
    eth_mux_sched_if #(.S_COUNT(4), .COUNT_WIDTH(16)) bus_fp ();

    eth_mux_sched #(.S_COUNT(4), .ARB_ROUND_ROBIN(1), .COUNT_WIDTH(16)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr.master)
    );

    eth_mux_sched #(.S_COUNT(4), .ARB_ROUND_ROBIN(0), .COUNT_WIDTH(16)) u_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  mask;
        logic        hdr;
        logic        tv;
        logic        tr;
        logic        tl;
        logic        en;
        logic [1:0]  sel;
        logic [3:0]  gnt;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_en_rr(output int cyc);
        cyc = 0;
        while (bus_rr.enable !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rr.wait_enable", int'(cyc < 20), 1);
    endtask

    task automatic wait_en_fp(output int cyc);
        cyc = 0;
        while (bus_fp.enable !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("fp.wait_enable", int'(cyc < 20), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int bad;
        int exp_order [5];

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_rr.req = '0; bus_rr.port_mask = '0; bus_rr.m_hdr_valid = 1'b0;
        bus_rr.m_tvalid = 1'b0; bus_rr.m_tready = 1'b0; bus_rr.m_tlast = 1'b0;
        bus_fp.req = '0; bus_fp.port_mask = '0; bus_fp.m_hdr_valid = 1'b0;
        bus_fp.m_tvalid = 1'b0; bus_fp.m_tready = 1'b0; bus_fp.m_tlast = 1'b0;

        //           rst   req   mask  hdr   tv    tr    tl  | en    sel   gnt   busy  cnt
        vecs[0]  = '{1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 16'd0};
        vecs[2]  = '{1'b0, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 16'd0};
        vecs[4]  = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 16'd0};
        vecs[5]  = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 16'd0};
        vecs[6]  = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'h4, 1'b1, 16'd0};
        vecs[7]  = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 16'd1};
        vecs[8]  = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 4'h0, 1'b0, 16'd1};
        vecs[9]  = '{1'b0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'h1, 1'b1, 16'd1};
        vecs[10] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 16'd1};
        vecs[11] = '{1'b0, 4'hB, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'h8, 1'b1, 16'd1};
        vecs[12] = '{1'b0, 4'hB, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'h8, 1'b1, 16'd1};
        vecs[13] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'h0, 1'b0, 16'd2};
        vecs[14] = '{1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'h0, 1'b0, 16'd2};
        vecs[15] = '{1'b0, 4'h4, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'h4, 1'b1, 16'd2};
        vecs[16] = '{1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 16'd2};
        vecs[17] = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'h4, 1'b1, 16'd2};
        vecs[18] = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 16'd0};
        vecs[19] = '{1'b0, 4'h3, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'h2, 1'b1, 16'd0};
        vecs[20] = '{1'b0, 4'h3, 4'hE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1, 16'd0};
        vecs[21] = '{1'b0, 4'h3, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'h0, 1'b0, 16'd0};
        vecs[22] = '{1'b0, 4'h3, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'h0, 1'b0, 16'd0};

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst                 = vecs[i].rst;
            bus_rr.req          = vecs[i].req;
            bus_rr.port_mask    = vecs[i].mask;
            bus_rr.m_hdr_valid  = vecs[i].hdr;
            bus_rr.m_tvalid     = vecs[i].tv;
            bus_rr.m_tready     = vecs[i].tr;
            bus_rr.m_tlast      = vecs[i].tl;
            @(posedge clk); #1;
            chk($sformatf("v%0d.enable", i), int'(bus_rr.enable), int'(vecs[i].en));
            chk($sformatf("v%0d.select", i), int'(bus_rr.select), int'(vecs[i].sel));
            chk($sformatf("v%0d.grant", i), int'(bus_rr.grant), int'(vecs[i].gnt));
            chk($sformatf("v%0d.busy", i), int'(bus_rr.busy), int'(vecs[i].busy));
            chk($sformatf("v%0d.frame_count", i), int'(bus_rr.frame_count), int'(vecs[i].cnt));
        end
        bus_rr.m_hdr_valid = 1'b0;
        bus_rr.m_tvalid = 1'b0; bus_rr.m_tready = 1'b0; bus_rr.m_tlast = 1'b0;

        // Round robin under full load with 1-beat frames.
        rst = 1'b1; bus_rr.req = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_rr.req = 4'hF; bus_rr.port_mask = 4'hF;
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            wait_en_rr(cyc);
            if (k > 0) chk($sformatf("rr.gap%0d", k), cyc + 1, 2);
            chk($sformatf("rr.select%0d", k), int'(bus_rr.select), exp_order[k]);
            chk($sformatf("rr.grant%0d", k), int'(bus_rr.grant), 1 << exp_order[k]);
            bus_rr.m_hdr_valid = 1'b1;
            @(posedge clk); #1;
            bus_rr.m_hdr_valid = 1'b0;
            chk($sformatf("rr.enable_drop%0d", k), int'(bus_rr.enable), 0);
            bus_rr.m_tvalid = 1'b1; bus_rr.m_tready = 1'b1; bus_rr.m_tlast = 1'b1;
            @(posedge clk); #1;
            bus_rr.m_tvalid = 1'b0; bus_rr.m_tready = 1'b0; bus_rr.m_tlast = 1'b0;
            chk($sformatf("rr.busy_end%0d", k), int'(bus_rr.busy), 0);
        end
        chk("rr.frame_count", int'(bus_rr.frame_count), 5);

        // Output backpressure for 20 cycles while every port keeps requesting.
        wait_en_rr(cyc);
        chk("bp.select_start", int'(bus_rr.select), 1);
        bus_rr.m_hdr_valid = 1'b1;
        @(posedge clk); #1;
        bus_rr.m_hdr_valid = 1'b0;
        bus_rr.m_tvalid = 1'b1; bus_rr.m_tready = 1'b1; bus_rr.m_tlast = 1'b0;
        @(posedge clk); #1;
        bus_rr.m_tready = 1'b0; bus_rr.m_tlast = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus_rr.select !== 2'd1 || bus_rr.busy !== 1'b1 ||
                bus_rr.enable !== 1'b0 || bus_rr.grant !== 4'h2) bad++;
        end
        chk("bp.stall_cycles_bad", bad, 0);
        bus_rr.m_tready = 1'b1;
        @(posedge clk); #1;
        bus_rr.m_tvalid = 1'b0; bus_rr.m_tready = 1'b0; bus_rr.m_tlast = 1'b0;
        chk("bp.busy_end", int'(bus_rr.busy), 0);
        chk("bp.frame_count", int'(bus_rr.frame_count), 6);
        wait_en_rr(cyc);
        chk("bp.next_select", int'(bus_rr.select), 2);
        bus_rr.req = '0;

        // Fixed priority: port 1 beats port 3 every time.
        bus_fp.req = 4'hA; bus_fp.port_mask = 4'hF;
        for (int k = 0; k < 3; k++) begin
            wait_en_fp(cyc);
            chk($sformatf("fp.select%0d", k), int'(bus_fp.select), 1);
            chk($sformatf("fp.grant%0d", k), int'(bus_fp.grant), 2);
            bus_fp.m_hdr_valid = 1'b1;
            @(posedge clk); #1;
            bus_fp.m_hdr_valid = 1'b0;
            bus_fp.m_tvalid = 1'b1; bus_fp.m_tready = 1'b1; bus_fp.m_tlast = 1'b1;
            @(posedge clk); #1;
            bus_fp.m_tvalid = 1'b0; bus_fp.m_tready = 1'b0; bus_fp.m_tlast = 1'b0;
        end
        chk("fp.frame_count", int'(bus_fp.frame_count), 3);
        bus_fp.req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
